crc_frame_checker: RTL and testbench

CRC_FRAME_CHECKER -- requirements
Module: crc_frame_checker

---
 rtl/crc_frame_checker.sv | 120 ++++++++++++
 tb/tb_crc_frame_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_checker.sv
// CRC-16 frame checker: runs an MSB-first CRC over each framed stream
// (payload followed by its CRC word(s)), reports the residue, length and
// pass/fail once per frame, and keeps saturating pass/fail counters.
module crc_frame_checker #(
  parameter int          DATA_W = 8,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'h0000,
  parameter int          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eof,
  output logic              res_valid,
  output logic              res_ok,
  output logic [15:0]       res_crc,
  output logic [CNT_W-1:0]  res_len,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  // A frame must be longer than its trailing CRC words to count as good.
  localparam logic [CNT_W-1:0] RUNT_LEN = CNT_W'(16 / DATA_W);

  logic [1:0]       state;
  logic [15:0]      crc;
  logic [CNT_W-1:0] len;

  logic             accept;
  logic             take;
  logic [15:0]      crc_base;
  logic [15:0]      crc_next;
  logic [CNT_W-1:0] len_base;
  logic [CNT_W-1:0] len_next;
  logic             ok_next;

  // DATA_W serial CRC steps, MSB of the word first.
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [DATA_W-1:0] d);
    logic [15:0]       r;
    logic [DATA_W-1:0] sd;
    logic              fb;
    r  = c;
    sd = d;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb = r[15] ^ sd[DATA_W-1];
      r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      sd = sd << 1;
    end
    return r;
  endfunction

  // Handshake, frame-step datapath and the pass/fail decision for the
  // word currently offered.
  always_comb begin
    s_ready   = reset && (state != REPORT);
    res_valid = (state == REPORT);
    accept    = s_valid && s_ready;
    // sof always restarts the frame; otherwise only words inside a frame count.
    take      = accept && (s_sof || state == RUN);
    crc_base  = s_sof ? INIT : crc;
    len_base  = s_sof ? '0 : len;
    crc_next  = crc_word(crc_base, s_data);
    len_next  = (len_base == '1) ? len_base : len_base + 1'b1;
    ok_next   = (crc_next == 16'h0000) && (len_next > RUNT_LEN);
  end

  // Frame FSM, result registers and saturating statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      crc     <= INIT;
      len     <= '0;
      res_ok  <= 1'b0;
      res_crc <= 16'h0000;
      res_len <= '0;
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (take) begin
            // A new sof while a frame is open abandons it as an error.
            if (state == RUN && s_sof && err_cnt != '1) begin
              err_cnt <= err_cnt + 1'b1;
            end
            crc <= crc_next;
            len <= len_next;
            if (s_eof) begin
              state   <= REPORT;
              res_ok  <= ok_next;
              res_crc <= crc_next;
              res_len <= len_next;
            end else begin
              state <= RUN;
            end
          end
        end
        REPORT: begin
          state <= IDLE;
          crc   <= INIT;
          len   <= '0;
          if (res_ok) begin
            if (ok_cnt != '1) ok_cnt <= ok_cnt + 1'b1;
          end else begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker: an 8-bit instance (INIT=0, 4-bit
// counters) and a 16-bit instance (INIT=FFFF), results checked through
// per-instance scoreboards.
module tb_crc_frame_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        v8, r8, sof8, eof8, rv8, ok8;
  logic [7:0]  d8;
  logic [15:0] crc8;
  logic [3:0]  len8, okc8, errc8;

  logic        v16, r16, sof16, eof16, rv16, ok16;
  logic [15:0] d16, crc16, len16, okc16, errc16;

  crc_frame_checker #(.DATA_W(8), .POLY(16'h1021), .INIT(16'h0000), .CNT_W(4)) u8 (
    .clk(clk), .reset(reset), .s_valid(v8), .s_ready(r8), .s_data(d8),
    .s_sof(sof8), .s_eof(eof8), .res_valid(rv8), .res_ok(ok8), .res_crc(crc8),
    .res_len(len8), .ok_cnt(okc8), .err_cnt(errc8)
  );

  crc_frame_checker #(.DATA_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .CNT_W(16)) u16 (
    .clk(clk), .reset(reset), .s_valid(v16), .s_ready(r16), .s_data(d16),
    .s_sof(sof16), .s_eof(eof16), .res_valid(rv16), .res_ok(ok16), .res_crc(crc16),
    .res_len(len16), .ok_cnt(okc16), .err_cnt(errc16)
  );

  typedef struct {
    logic        ok;
    logic [15:0] crc;
    logic [15:0] len;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t m8, m16;
  logic [7:0]  pl[$];
  logic [15:0] pw[$];

  int checks   = 0;
  int failures = 0;

  function automatic exp_t mk(input logic ok, input logic [15:0] crc, input logic [15:0] len);
    exp_t e;
    e.ok  = ok;
    e.crc = crc;
    e.len = len;
    return e;
  endfunction

  // Reference CRC-CCITT bit-serial update over the low nbits of d.
  function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [15:0] d, input int nbits);
    logic fb;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
  endtask

  // Scoreboards: every result strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rv8 === 1'b1) begin
      if (q8.size() == 0) chk("u8 spurious res_valid", rv8, 0);
      else begin
        m8 = q8.pop_front();
        chk("u8 res_ok", ok8, m8.ok);
        chk("u8 res_crc", crc8, m8.crc);
        chk("u8 res_len", len8, m8.len);
      end
    end
    if (rv16 === 1'b1) begin
      if (q16.size() == 0) chk("u16 spurious res_valid", rv16, 0);
      else begin
        m16 = q16.pop_front();
        chk("u16 res_ok", ok16, m16.ok);
        chk("u16 res_crc", crc16, m16.crc);
        chk("u16 res_len", len16, m16.len);
      end
    end
  end

  task automatic send8(input logic [7:0] d, input logic sof, input logic eof);
    int n = 0;
    @(negedge clk);
    while (r8 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("u8 ready timeout", r8, 1);
    v8 = 1'b1; d8 = d; sof8 = sof; eof8 = eof;
    @(posedge clk);
    #1 v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] d, input logic sof, input logic eof);
    int n = 0;
    @(negedge clk);
    while (r16 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("u16 ready timeout", r16, 1);
    v16 = 1'b1; d16 = d; sof16 = sof; eof16 = eof;
    @(posedge clk);
    #1 v16 = 1'b0; sof16 = 1'b0; eof16 = 1'b0;
  endtask

  // Sends pl; with eof_last the expectation is queued and latency checked,
  // returning once the counters reflect the frame.
  task automatic burst8(input logic sof_first, input logic eof_last, input exp_t e);
    for (int i = 0; i < pl.size(); i++) begin
      if (eof_last && i == pl.size() - 1) q8.push_back(e);
      send8(pl[i], sof_first && i == 0, eof_last && i == pl.size() - 1);
    end
    if (eof_last) begin
      @(negedge clk);
      chk("u8 latency res_valid", rv8, 1);
      chk("u8 ready low in report", r8, 0);
      @(negedge clk);
    end
  endtask

  task automatic burst16(input exp_t e);
    for (int i = 0; i < pw.size(); i++) begin
      if (i == pw.size() - 1) q16.push_back(e);
      send16(pw[i], i == 0, i == pw.size() - 1);
    end
    @(negedge clk);
    chk("u16 latency res_valid", rv16, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c, cw;
    logic        okm;
    reset = 1'b0;
    v8 = 0; d8 = '0; sof8 = 0; eof8 = 0;
    v16 = 0; d16 = '0; sof16 = 0; eof16 = 0;
    repeat (3) @(negedge clk);
    chk("reset s_ready", r8, 0);
    chk("reset res_valid", rv8, 0);
    chk("reset res_ok", ok8, 0);
    chk("reset res_crc", crc8, 0);
    chk("reset res_len", len8, 0);
    chk("reset ok_cnt", okc8, 0);
    chk("reset err_cnt", errc8, 0);
    chk("reset u16 s_ready", r16, 0);
    reset = 1'b1;
    #1 chk("ready after release", r8, 1);

    // Words without sof while idle are ignored.
    send8(8'hAA, 0, 0);
    send8(8'h55, 0, 1);
    repeat (3) @(negedge clk);
    chk("idle drop ok_cnt", okc8, 0);
    chk("idle drop err_cnt", errc8, 0);

    // "123456789" + 31 C3, with a valid-low gap mid-frame.
    pl.delete(); add_str("12345");
    burst8(1, 0, mk(0, 0, 0));
    repeat (6) @(negedge clk);
    pl.delete(); add_str("6789"); pl.push_back(8'h31); pl.push_back(8'hC3);
    burst8(0, 1, mk(1, 16'h0000, 11));
    chk("good ok_cnt", okc8, 1);
    chk("good err_cnt", errc8, 0);
    repeat (3) @(negedge clk);
    chk("hold res_len", len8, 11);
    chk("hold res_ok", ok8, 1);

    // Corrupted last byte.
    pl.delete(); add_str("123456789"); pl.push_back(8'h31); pl.push_back(8'hC2);
    c = 16'h0000;
    foreach (pl[i]) c = model_crc(c, {8'h00, pl[i]}, 8);
    burst8(1, 1, mk(0, c, 11));
    chk("bad residue nonzero", crc8 != 16'h0000, 1);
    chk("bad err_cnt", errc8, 1);
    chk("bad ok_cnt", okc8, 1);

    // Frame A aborted by the sof of good frame B.
    pl.delete(); add_str("ABCD");
    burst8(1, 0, mk(0, 0, 0));
    pl.delete(); add_str("123456789"); pl.push_back(8'h31); pl.push_back(8'hC3);
    burst8(1, 1, mk(1, 16'h0000, 11));
    chk("abort err_cnt", errc8, 2);
    chk("abort ok_cnt", okc8, 2);

    // Runts: single 0x00 beat, and two zero bytes (zero residue, CRC-only).
    pl.delete(); pl.push_back(8'h00);
    burst8(1, 1, mk(0, 16'h0000, 1));
    chk("runt1 err_cnt", errc8, 3);
    pl.delete(); pl.push_back(8'h00); pl.push_back(8'h00);
    burst8(1, 1, mk(0, 16'h0000, 2));
    chk("runt2 err_cnt", errc8, 4);
    pl.delete(); repeat (3) pl.push_back(8'h00);
    burst8(1, 1, mk(1, 16'h0000, 3));
    chk("len3 ok_cnt", okc8, 3);

    // Reset in the middle of a frame discards it.
    pl.delete(); add_str("123");
    burst8(1, 0, mk(0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset s_ready", r8, 0);
    chk("midreset res_valid", rv8, 0);
    chk("midreset ok_cnt", okc8, 0);
    chk("midreset err_cnt", errc8, 0);
    chk("midreset res_len", len8, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pl.delete(); add_str("456789"); pl.push_back(8'h31); pl.push_back(8'hC3);
    burst8(0, 0, mk(0, 0, 0));
    send8(8'h00, 0, 1);
    repeat (4) @(negedge clk);
    chk("after reset ok_cnt", okc8, 0);
    chk("after reset err_cnt", errc8, 0);

    // Length saturation on the 4-bit counter; frame still checked.
    pl.delete(); repeat (20) pl.push_back(8'h00);
    burst8(1, 1, mk(1, 16'h0000, 15));
    chk("sat len ok_cnt", okc8, 1);

    // err_cnt saturation.
    repeat (15) begin
      pl.delete(); pl.push_back(8'h00);
      burst8(1, 1, mk(0, 16'h0000, 1));
    end
    chk("err_cnt at max", errc8, 15);
    pl.delete(); pl.push_back(8'h00);
    burst8(1, 1, mk(0, 16'h0000, 1));
    chk("err_cnt saturated", errc8, 15);
    chk("ok_cnt untouched", okc8, 1);

    // 16-bit instance: "12345678" plus its model-computed check word.
    pw.delete();
    pw.push_back(16'h3132); pw.push_back(16'h3334);
    pw.push_back(16'h3536); pw.push_back(16'h3738);
    c = 16'hFFFF;
    foreach (pw[i]) c = model_crc(c, pw[i], 16);
    cw = c;
    pw.push_back(cw);
    burst16(mk(1, 16'h0000, 5));
    chk("u16 ok_cnt", okc16, 1);

    // Same payload with the fixed 0x29B1 check word.
    pw[4] = 16'h29B1;
    c = 16'hFFFF;
    foreach (pw[i]) c = model_crc(c, pw[i], 16);
    okm = (c == 16'h0000);
    burst16(mk(okm, c, 5));
    chk("u16 ok_cnt 2", okc16, okm ? 2 : 1);

    // Single word with zero residue is still a runt for 16-bit words.
    pw.delete(); pw.push_back(16'hFFFF);
    burst16(mk(0, 16'h0000, 1));
    chk("u16 runt err_cnt", errc16, okm ? 1 : 2);

    repeat (3) @(negedge clk);
    chk("u8 scoreboard drained", q8.size(), 0);
    chk("u16 scoreboard drained", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
